// File: rtl/seg_scan_mux_pkg.sv
// Shared types and constants for the 4-digit scan multiplexer.
// State encoding, digit count, anode-off pattern, leading-zero helper.
package seg_scan_mux_pkg;

   typedef enum logic {
      DARK  = 1'b0,
      DRIVE = 1'b1
   } state_e;

   localparam int         NUM_DIGITS = 4;
   localparam logic [3:0] AN_OFF     = 4'b1111;

   // True when digit i is above digit 0 and it and every digit above are 0.
   function automatic logic lead_zero(
      input logic [15:0] v,
      input logic [1:0]  i
   );
      logic z;
      z = (i != 2'd0);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k >= int'(i) && v[4*k +: 4] != 4'h0) begin
            z = 1'b0;
         end
      end
      return z;
   endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Terminal-count phase counter for the scan multiplexer.
// Pulses done on the last cycle of a len-cycle phase, then restarts from 0.
module seg_scan_prescaler
   import seg_scan_mux_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] len,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Terminal count and self-clear so every phase starts at zero.
   always_comb begin
      done  = (cnt_q == len - CNT_W'(1));
      cnt_d = done ? '0 : cnt_q + CNT_W'(1);
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 4-digit scanner feeding the 7-segment decoder.
// Shadowed digits, dead-time between slots, blanking and zero suppression.
module seg_scan_mux #(
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] value_in,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   input  logic        lz_en,
   output logic [3:0]  nibble_out,
   output logic [3:0]  an_n,
   output logic        dp_n,
   output logic [1:0]  digit_idx
);

   import seg_scan_mux_pkg::*;

   localparam logic [CNT_W-1:0] DRIVE_LEN = CNT_W'(REFRESH_DIV);
   localparam logic [CNT_W-1:0] DARK_LEN  = CNT_W'(DEAD_CYCLES);

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        first_q, first_d;
   logic [15:0] val_q, val_d;
   logic [3:0]  dp_q, dp_d;
   logic [3:0]  blank_q, blank_d;
   logic [3:0]  an_n_q, an_n_d;
   logic        dp_n_q, dp_n_d;
   logic [3:0]  nib_q, nib_d;
   logic [CNT_W-1:0] len;
   logic        done;
   logic        sup;

   assign len = (state_q == DRIVE) ? DRIVE_LEN : DARK_LEN;

   seg_scan_prescaler #(
      .CNT_W (CNT_W)
   ) u_presc (
      .clk  (clk),
      .rst  (rst),
      .len  (len),
      .done (done)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DARK;
         idx_q   <= 2'd0;
         first_q <= 1'b1;
         val_q   <= 16'h0000;
         dp_q    <= 4'h0;
         blank_q <= 4'h0;
         an_n_q  <= AN_OFF;
         dp_n_q  <= 1'b1;
         nib_q   <= 4'h0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         first_q <= first_d;
         val_q   <= val_d;
         dp_q    <= dp_d;
         blank_q <= blank_d;
         an_n_q  <= an_n_d;
         dp_n_q  <= dp_n_d;
         nib_q   <= nib_d;
      end
   end

   // Phase sequencing; the first dark phase after reset keeps digit 0.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      first_d = first_q;
      if (done) begin
         unique case (state_q)
            DARK: begin
               state_d = DRIVE;
               first_d = 1'b0;
               if (!first_q) begin
                  idx_d = idx_q + 2'd1;
               end
            end
            DRIVE: begin
               state_d = DARK;
            end
         endcase
      end
   end

   // Shadow capture of the digit codes, decimal points and blanks.
   always_comb begin
      val_d   = val_q;
      dp_d    = dp_q;
      blank_d = blank_q;
      if (load) begin
         val_d   = value_in;
         dp_d    = dp_in;
         blank_d = blank_in;
      end
   end

   // Registered outputs follow the upcoming state and shadow contents.
   always_comb begin
      an_n_d = AN_OFF;
      dp_n_d = 1'b1;
      nib_d  = nib_q;
      sup    = blank_d[idx_d] | (lz_en & lead_zero(val_d, idx_d));
      if (state_d == DRIVE) begin
         nib_d = val_d[{idx_d, 2'b00} +: 4];
         if (!sup) begin
            an_n_d = ~(4'b0001 << idx_d);
            dp_n_d = ~dp_d[idx_d];
         end
      end
   end

   assign nibble_out = nib_q;
   assign an_n       = an_n_q;
   assign dp_n       = dp_n_q;
   assign digit_idx  = idx_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with REFRESH_DIV=4, DEAD_CYCLES=1.
// Each slot is 4 drive cycles then 1 dark cycle; outputs sampled 1ns after clk.
module tb_seg_scan_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        lz_en;
   logic [3:0]  nibble_out;
   logic [3:0]  an_n;
   logic        dp_n;
   logic [1:0]  digit_idx;

   int tests = 0;
   int fails = 0;

   seg_scan_mux #(
      .REFRESH_DIV (4),
      .DEAD_CYCLES (1),
      .CNT_W       (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .lz_en      (lz_en),
      .nibble_out (nibble_out),
      .an_n       (an_n),
      .dp_n       (dp_n),
      .digit_idx  (digit_idx)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] e_an,
                      input logic [3:0] e_nib, input logic e_dp,
                      input logic [1:0] e_idx);
      cmp({tag, ".an_n"}, {4'h0, an_n}, {4'h0, e_an});
      cmp({tag, ".nib"}, {4'h0, nibble_out}, {4'h0, e_nib});
      cmp({tag, ".dp_n"}, {7'h0, dp_n}, {7'h0, e_dp});
      cmp({tag, ".idx"}, {6'h0, digit_idx}, {6'h0, e_idx});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full slot: 4 drive cycles, then the dark cycle holding the nibble.
   // Any load set up by the caller is dropped after the first edge.
   task automatic slot(input string tag, input logic [3:0] e_an,
                       input logic [3:0] e_nib, input logic e_dp,
                       input logic [1:0] e_idx);
      for (int c = 0; c < 4; c++) begin
         step();
         load = 1'b0;
         chk($sformatf("%s.drv%0d", tag, c), e_an, e_nib, e_dp, e_idx);
      end
      step();
      chk({tag, ".dark"}, 4'b1111, e_nib, 1'b1, e_idx);
   endtask

   task automatic ld(input logic [15:0] v, input logic [3:0] d,
                     input logic [3:0] b);
      load     = 1'b1;
      value_in = v;
      dp_in    = d;
      blank_in = b;
   endtask

   initial begin
      rst      = 1'b1;
      load     = 1'b0;
      value_in = 16'h0;
      dp_in    = 4'h0;
      blank_in = 4'h0;
      lz_en    = 1'b0;
      step();
      step();
      chk("reset", 4'b1111, 4'h0, 1'b1, 2'd0);
      rst = 1'b0;

      // Scan sequence with first DARK not advancing
      ld(16'h1234, 4'h0, 4'h0);
      slot("s1.d0", 4'b1110, 4'h4, 1'b1, 2'd0);
      slot("s1.d1", 4'b1101, 4'h3, 1'b1, 2'd1);
      slot("s1.d2", 4'b1011, 4'h2, 1'b1, 2'd2);
      slot("s1.d3", 4'b0111, 4'h1, 1'b1, 2'd3);
      slot("s1.wrap", 4'b1110, 4'h4, 1'b1, 2'd0);

      // Blank digit 2, decimal point on digit 1
      ld(16'h1234, 4'b0010, 4'b0100);
      slot("s2.d1", 4'b1101, 4'h3, 1'b0, 2'd1);
      slot("s2.d2", 4'b1111, 4'h2, 1'b1, 2'd2);
      slot("s2.d3", 4'b0111, 4'h1, 1'b1, 2'd3);
      slot("s2.d0", 4'b1110, 4'h4, 1'b1, 2'd0);
      slot("s2.d1b", 4'b1101, 4'h3, 1'b0, 2'd1);

      // Leading-zero suppression
      lz_en = 1'b1;
      ld(16'h0070, 4'h0, 4'h0);
      slot("s3a.d2", 4'b1111, 4'h0, 1'b1, 2'd2);
      slot("s3a.d3", 4'b1111, 4'h0, 1'b1, 2'd3);
      slot("s3a.d0", 4'b1110, 4'h0, 1'b1, 2'd0);
      slot("s3a.d1", 4'b1101, 4'h7, 1'b1, 2'd1);
      ld(16'h0000, 4'h0, 4'h0);
      slot("s3b.d2", 4'b1111, 4'h0, 1'b1, 2'd2);
      slot("s3b.d3", 4'b1111, 4'h0, 1'b1, 2'd3);
      slot("s3b.d0", 4'b1110, 4'h0, 1'b1, 2'd0);
      slot("s3b.d1", 4'b1111, 4'h0, 1'b1, 2'd1);
      lz_en = 1'b0;
      slot("s3c.d2", 4'b1011, 4'h0, 1'b1, 2'd2);
      slot("s3c.d3", 4'b0111, 4'h0, 1'b1, 2'd3);
      slot("s3c.d0", 4'b1110, 4'h0, 1'b1, 2'd0);
      slot("s3c.d1", 4'b1101, 4'h0, 1'b1, 2'd1);
      slot("s3c.d2b", 4'b1011, 4'h0, 1'b1, 2'd2);
      slot("s3c.d3b", 4'b0111, 4'h0, 1'b1, 2'd3);

      // Mid-slot load during digit 0
      step();
      chk("s4.c1", 4'b1110, 4'h0, 1'b1, 2'd0);
      step();
      chk("s4.c2", 4'b1110, 4'h0, 1'b1, 2'd0);
      ld(16'h000A, 4'h0, 4'h0);
      step();
      load = 1'b0;
      chk("s4.c3", 4'b1110, 4'hA, 1'b1, 2'd0);
      step();
      chk("s4.c4", 4'b1110, 4'hA, 1'b1, 2'd0);
      step();
      chk("s4.dark", 4'b1111, 4'hA, 1'b1, 2'd0);
      slot("s4.d1", 4'b1101, 4'h0, 1'b1, 2'd1);
      slot("s4.d2", 4'b1011, 4'h0, 1'b1, 2'd2);

      // Load on the last drive cycle of digit 3
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("s5.c%0d", c), 4'b0111, 4'h0, 1'b1, 2'd3);
      end
      ld(16'h5000, 4'h0, 4'h0);
      step();
      load = 1'b0;
      chk("s5.dark", 4'b1111, 4'h0, 1'b1, 2'd3);
      slot("s5.d0", 4'b1110, 4'h0, 1'b1, 2'd0);
      slot("s5.d1", 4'b1101, 4'h0, 1'b1, 2'd1);
      slot("s5.d2", 4'b1011, 4'h0, 1'b1, 2'd2);
      slot("s5.d3", 4'b0111, 4'h5, 1'b1, 2'd3);

      // Asynchronous reset during digit 2 drive
      ld(16'h4321, 4'b0100, 4'h0);
      slot("s6.d0", 4'b1110, 4'h1, 1'b1, 2'd0);
      slot("s6.d1", 4'b1101, 4'h2, 1'b1, 2'd1);
      step();
      step();
      chk("s6.pre", 4'b1011, 4'h3, 1'b0, 2'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("s6.async", 4'b1111, 4'h0, 1'b1, 2'd0);
      step();
      rst = 1'b0;
      slot("s6.r0", 4'b1110, 4'h0, 1'b1, 2'd0);
      slot("s6.r1", 4'b1101, 4'h0, 1'b1, 2'd1);
      slot("s6.r2", 4'b1011, 4'h0, 1'b1, 2'd2);
      slot("s6.r3", 4'b0111, 4'h0, 1'b1, 2'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
